// File: rtl/sha3_axis_pad_packer.sv
// AXI4-Stream absorb front-end: packs message bytes into Keccak rate blocks
// and applies SHA3 domain padding (0x06 ... 0x80) before handing blocks to the core.
module sha3_axis_pad_packer #(
  parameter int WIDTH  = 16,
  parameter int KEEP_W = WIDTH/8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [WIDTH-1:0]  S_TDATA,
  input  logic [KEEP_W-1:0] S_TKEEP,
  input  logic              S_TLAST,
  input  logic [1:0]        S_TUSER,
  input  logic              S_TVALID,
  output logic              S_TREADY,
  output logic [1599:0]     BLK_DATA,
  output logic [1:0]        BLK_MODE,
  output logic              BLK_FIRST,
  output logic              BLK_LAST,
  output logic              BLK_VALID,
  input  logic              BLK_READY
);

  localparam int KSH = $clog2(KEEP_W);

  typedef enum logic [1:0] {FILL, EMIT, PAD} state_t;

  state_t          state_q, state_d;
  logic [1599:0]   buf_q, buf_d;
  logic [7:0]      wcnt_q, wcnt_d;
  logic [1:0]      mode_q, mode_d;
  logic            first_pend_q, first_pend_d;
  logic            pad_pend_q, pad_pend_d;
  logic            blk_first_q, blk_first_d;
  logic            blk_last_q, blk_last_d;
  logic            s_tready_q, blk_valid_q;

  logic            beat;
  logic [1:0]      mode_eff;
  logic [7:0]      rate, words, p, q, kcnt;
  logic [KEEP_W-1:0] keep_eff;
  logic [10:0]     pbase;

  function automatic logic [7:0] rate_of(input logic [1:0] m);
    case (m)
      2'd0:    rate_of = 8'd144;
      2'd1:    rate_of = 8'd136;
      2'd2:    rate_of = 8'd104;
      default: rate_of = 8'd72;
    endcase
  endfunction

  // The first beat of a message sizes the block from S_TUSER before it is latched.
  assign beat     = S_TVALID && s_tready_q;
  assign mode_eff = first_pend_q ? S_TUSER : mode_q;
  assign rate     = rate_of(mode_eff);
  assign words    = rate >> KSH;
  assign keep_eff = S_TLAST ? S_TKEEP : {KEEP_W{1'b1}};
  assign p        = wcnt_q * 8'(KEEP_W);
  assign pbase    = {p, 3'b000};
  assign q        = p + kcnt;

  always_comb begin
    kcnt = 8'd0;
    for (int i = 0; i < KEEP_W; i++) kcnt = kcnt + 8'(keep_eff[i]);
  end

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    wcnt_d       = wcnt_q;
    mode_d       = mode_q;
    first_pend_d = first_pend_q;
    pad_pend_d   = pad_pend_q;
    blk_first_d  = blk_first_q;
    blk_last_d   = blk_last_q;
    case (state_q)
      FILL: if (beat) begin
        for (int i = 0; i < KEEP_W; i++)
          buf_d[pbase + 11'(8*i) +: 8] = keep_eff[i] ? S_TDATA[8*i +: 8] : 8'h00;
        wcnt_d = wcnt_q + 8'd1;
        if (first_pend_q) begin
          mode_d       = S_TUSER;
          first_pend_d = 1'b0;
          blk_first_d  = 1'b1;
        end
        if (S_TLAST) begin
          state_d = EMIT;
          if (q < rate) begin
            // q == R-1 lands both pad bytes on one position, giving 0x86
            buf_d[{q, 3'b000} +: 8]             = buf_d[{q, 3'b000} +: 8] ^ 8'h06;
            buf_d[{rate - 8'd1, 3'b000} +: 8]   = buf_d[{rate - 8'd1, 3'b000} +: 8] ^ 8'h80;
            blk_last_d = 1'b1;
          end else begin
            pad_pend_d = 1'b1;
            blk_last_d = 1'b0;
          end
        end else if ((wcnt_q + 8'd1) == words) begin
          state_d    = EMIT;
          blk_last_d = 1'b0;
        end
      end
      EMIT: if (BLK_READY) begin
        buf_d       = '0;
        wcnt_d      = 8'd0;
        blk_first_d = 1'b0;
        if (pad_pend_q) begin
          pad_pend_d = 1'b0;
          state_d    = PAD;
          buf_d[7:0] = 8'h06;
          buf_d[{rate - 8'd1, 3'b000} +: 8] = 8'h80;
          blk_last_d = 1'b1;
        end else begin
          state_d = FILL;
          if (blk_last_q) first_pend_d = 1'b1;
          blk_last_d = 1'b0;
        end
      end
      PAD: if (BLK_READY) begin
        state_d      = FILL;
        buf_d        = '0;
        blk_last_d   = 1'b0;
        first_pend_d = 1'b1;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= FILL;
      buf_q        <= '0;
      wcnt_q       <= 8'd0;
      mode_q       <= 2'd0;
      first_pend_q <= 1'b1;
      pad_pend_q   <= 1'b0;
      blk_first_q  <= 1'b0;
      blk_last_q   <= 1'b0;
      s_tready_q   <= 1'b0;
      blk_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      wcnt_q       <= wcnt_d;
      mode_q       <= mode_d;
      first_pend_q <= first_pend_d;
      pad_pend_q   <= pad_pend_d;
      blk_first_q  <= blk_first_d;
      blk_last_q   <= blk_last_d;
      s_tready_q   <= (state_d == FILL);
      blk_valid_q  <= (state_d != FILL);
    end
  end

  assign S_TREADY  = s_tready_q;
  assign BLK_VALID = blk_valid_q;
  assign BLK_DATA  = buf_q;
  assign BLK_MODE  = mode_q;
  assign BLK_FIRST = blk_first_q;
  assign BLK_LAST  = blk_last_q;

endmodule
